// File: rtl/result_uart_pkg.sv
// Shared types and constants for the benchmark-result UART transmitter.
package result_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic [4:0] TAG_PREFIX = 5'b10100;
    localparam int         ENTRY_W    = 11;

    // Tag frame identifies which wrapper output the following data byte came from.
    function automatic logic [7:0] tag_byte(input logic [2:0] sel_code);
        return {TAG_PREFIX, sel_code};
    endfunction

endpackage

// File: rtl/result_uart_tx_fifo.sv
// Small synchronous FIFO of {sel,data} entries; wrap-bit pointers give full/empty.
module result_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO can still take a push when a slot is freed on the same clock.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/result_uart_tx.sv
// Captures {sel,data_in} pairs on request or change and sends each as a tag
// frame followed by a data frame, 8N1, on a single UART line.
module result_uart_tx
    import result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int SEND_ON_CHANGE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] sel,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic          CHANGE_EN = (SEND_ON_CHANGE != 0);

    uart_state_t        r_state;
    uart_state_t        w_state_nx;
    logic [BW-1:0]      r_baud_cnt;
    logic [BW-1:0]      w_baud_nx;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_nx;
    logic               r_byte_idx;
    logic               w_byte_nx;
    logic [ENTRY_W-1:0] r_entry;
    logic [ENTRY_W-1:0] w_entry_nx;
    logic               r_tx;
    logic               w_tx_nx;
    logic               r_busy;
    logic [2:0]         r_prev_sel;
    logic [7:0]         r_prev_data;
    logic               r_primed;
    logic               r_overflow;

    logic               w_change;
    logic               w_push_req;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_baud_done;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [ENTRY_W-1:0] w_fifo_data;
    logic [7:0]         w_byte_sel;

    assign w_change   = r_primed & CHANGE_EN &
                        ((sel != r_prev_sel) | (data_in != r_prev_data));
    assign w_push_req = send | w_change;
    assign w_push_ok  = w_push_req & (~w_fifo_full | w_pop);

    result_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push_ok),
        .i_data  ({sel, data_in}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // First clock after reset only primes the history, so reset release never looks like a change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_sel  <= '0;
            r_prev_data <= '0;
            r_primed    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_prev_sel  <= sel;
            r_prev_data <= data_in;
            r_primed    <= 1'b1;
            if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_baud_nx   = r_baud_cnt;
        w_bit_nx    = r_bit_idx;
        w_byte_nx   = r_byte_idx;
        w_entry_nx  = r_entry;
        w_pop       = 1'b0;
        w_baud_done = (r_baud_cnt == BAUD_MAX);
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = START;
                    w_baud_nx  = '0;
                    w_byte_nx  = 1'b0;
                    w_entry_nx = w_fifo_data;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_state_nx = DATA;
                    w_baud_nx  = '0;
                    w_bit_nx   = 3'd0;
                end else begin
                    w_baud_nx = r_baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_nx = '0;
                    if (r_bit_idx == 3'd7) w_state_nx = STOP;
                    else                   w_bit_nx   = r_bit_idx + 3'd1;
                end else begin
                    w_baud_nx = r_baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_nx = '0;
                    if (!r_byte_idx) begin
                        w_state_nx = START;
                        w_byte_nx  = 1'b1;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_baud_nx = r_baud_cnt + BAUD_ONE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Line level is computed from the next state so tx and busy are clean registered outputs.
    always_comb begin
        w_byte_sel = w_byte_nx ? w_entry_nx[7:0] : tag_byte(w_entry_nx[10:8]);
        case (w_state_nx)
            START:   w_tx_nx = 1'b0;
            DATA:    w_tx_nx = w_byte_sel[w_bit_nx];
            default: w_tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= 1'b0;
            r_entry    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_baud_cnt <= w_baud_nx;
            r_bit_idx  <= w_bit_nx;
            r_byte_idx <= w_byte_nx;
            r_entry    <= w_entry_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= (w_state_nx != IDLE);
        end
    end

    assign tx        = r_tx;
    assign busy      = r_busy;
    assign fifo_full = w_fifo_full;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: frame timing, change detect, FIFO overflow, async reset.
module tb_result_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [2:0] sel = '0;
    logic [7:0] data_in = '0;
    logic       send = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int waited;

    always #5 clk = ~clk;

    result_uart_tx #(
        .CLKS_PER_BIT   (CPB),
        .FIFO_DEPTH     (4),
        .SEND_ON_CHANGE (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sel       (sel),
        .data_in   (data_in),
        .send      (send),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] s, input logic [7:0] d, input logic snd);
        sel     = s;
        data_in = d;
        send    = snd;
    endtask

    task automatic doReset(input logic [2:0] s, input logic [7:0] d);
        reset_n = 1'b0;
        applyStimulus(s, d, 1'b0);
        #1;
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset fifo_full", 32'(fifo_full), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    // Line must stay idle-high and not busy for n clocks.
    task automatic checkIdle(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    // Compares every clock of a tag+data frame pair; startIdx < 0 waits for the start bit first.
    task automatic checkPair(input string tag, input logic [2:0] s, input logic [7:0] d,
                             input int startIdx, output int waitCnt);
        logic [19:0] pv;
        int          badClk;
        int          first;
        pv      = {1'b1, d, 1'b0, 1'b1, 5'b10100, s, 1'b0};
        waitCnt = 0;
        first   = startIdx;
        if (startIdx < 0) begin
            first = 0;
            do begin
                tick();
                waitCnt++;
            end while (tx !== 1'b0 && waitCnt < 400);
            checkOutput({tag, " start"}, 32'(tx), 32'd0);
        end
        badClk = -1;
        for (int c = first; c < 20 * CPB; c++) begin
            if (c != first) tick();
            if (badClk < 0 && (tx !== pv[c / CPB] || busy !== 1'b1)) badClk = c;
        end
        checkOutput({tag, " bits"}, 32'(badClk), 32'hFFFF_FFFF);
    endtask

    initial begin
        #1;
        // Scenario 1: static inputs through reset release
        doReset(3'd5, 8'hA5);
        checkIdle("t1 idle after release", 100);
        checkOutput("t1 overflow", 32'(overflow), 32'd0);

        // Scenario 2: single send pulse
        doReset(3'd2, 8'h3C);
        applyStimulus(3'd2, 8'h3C, 1'b1);
        tick();
        applyStimulus(3'd2, 8'h3C, 1'b0);
        checkOutput("t2 tx before start", 32'(tx), 32'd1);
        checkPair("t2 pair", 3'd2, 8'h3C, -1, waited);
        checkOutput("t2 latency", 32'(waited), 32'd1);
        checkIdle("t2 after", 20);

        // Scenario 3: one-clock data glitch gives two entries
        doReset(3'd0, 8'h00);
        applyStimulus(3'd0, 8'h01, 1'b0);
        tick();
        applyStimulus(3'd0, 8'h00, 1'b0);
        checkPair("t3 pair1", 3'd0, 8'h01, -1, waited);
        checkOutput("t3 latency", 32'(waited), 32'd1);
        checkPair("t3 pair2", 3'd0, 8'h00, -1, waited);
        checkOutput("t3 gap", 32'(waited), 32'd2);
        checkIdle("t3 after", 100);

        // Scenario 4: six consecutive changes overflow the FIFO
        doReset(3'd1, 8'h00);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'd1, 8'h10 + 8'(i), 1'b0);
            if (i < 5) tick();
        end
        checkPair("t4 pair0", 3'd1, 8'h10, 3, waited);
        checkOutput("t4 fifo_full", 32'(fifo_full), 32'd1);
        checkOutput("t4 overflow", 32'(overflow), 32'd1);
        for (int k = 1; k < 5; k++) begin
            checkPair("t4 pairN", 3'd1, 8'h10 + 8'(k), -1, waited);
            checkOutput("t4 gap", 32'(waited), 32'd2);
        end
        checkIdle("t4 sixth dropped", 100);
        checkOutput("t4 fifo drained", 32'(fifo_full), 32'd0);
        checkOutput("t4 overflow sticky", 32'(overflow), 32'd1);

        // Scenario 5: send coincident with a change enqueues once
        doReset(3'd3, 8'h00);
        applyStimulus(3'd3, 8'h55, 1'b1);
        tick();
        applyStimulus(3'd3, 8'h55, 1'b0);
        checkPair("t5 pair", 3'd3, 8'h55, -1, waited);
        checkOutput("t5 latency", 32'(waited), 32'd1);
        checkIdle("t5 single entry", 100);
        checkOutput("t5 overflow", 32'(overflow), 32'd0);

        // Scenario 6: reset during tag data bits with a second entry queued
        doReset(3'd4, 8'h00);
        applyStimulus(3'd4, 8'h00, 1'b1);
        tick();
        tick();
        applyStimulus(3'd4, 8'h00, 1'b0);
        checkOutput("t6 frame started", 32'(tx), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("t6 mid-frame tx", 32'(tx), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6 async tx", 32'(tx), 32'd1);
        checkOutput("t6 async busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        checkIdle("t6 fifo discarded", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
